// File: rtl/roteador_arbitro_if.sv
// rtl/roteador_arbitro_if.sv - request/data/handshake bundle between producers, arbiter and consumer
interface roteador_arbitro_if #(
  parameter int DATA_W   = 4,
  parameter int SEL_BITS = 2
) ();
  logic [3:0]          req;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic [DATA_W-1:0]   c;
  logic [DATA_W-1:0]   d;
  logic                out_ready;
  logic [3:0]          gnt;
  logic [SEL_BITS-1:0] sel;
  logic [DATA_W-1:0]   saida;
  logic                out_valid;
  logic                busy;

  modport master (
    output req, a, b, c, d, out_ready,
    input  gnt, sel, saida, out_valid, busy
  );

  modport slave (
    input  req, a, b, c, d, out_ready,
    output gnt, sel, saida, out_valid, busy
  );
endinterface

// File: rtl/roteador_arbitro.sv
// rtl/roteador_arbitro.sv - round-robin arbiter with bounded bursts for the shared 4-way output
module roteador_arbitro #(
  parameter int DATA_W    = 4,
  parameter int SEL_BITS  = 2,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst_n,
  roteador_arbitro_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  count_q, count_d;

  logic        out_valid;
  logic        xfer;
  logic        release_now;
  logic [1:0]  arb_ptr;
  logic [1:0]  winner;
  logic [DATA_W-1:0] data_sel;

  // First set bit scanning p, p+1, ... mod 4; lower offsets overwrite higher ones.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + i[1:0];
      if (r[idx]) pick = idx;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    count_d     = count_q;
    out_valid   = (state_q == GRANT) && bus.req[sel_q];
    xfer        = out_valid && bus.out_ready;
    release_now = (state_q == GRANT) &&
                  (!bus.req[sel_q] || (xfer && (count_q == 4'(MAX_BURST - 1))));
    // On release the just-served requester moves to the back of the scan order.
    arb_ptr     = release_now ? sel_q + 2'd1 : ptr_q;
    winner      = pick(bus.req, arb_ptr);

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = 4'b0001 << winner;
          count_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d   = arb_ptr;
          count_d = '0;
          if (|bus.req) begin
            sel_d = winner;
            gnt_d = 4'b0001 << winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (xfer) begin
          count_d = count_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_sel = '0;
    if (out_valid) begin
      case (sel_q)
        2'd0:    data_sel = bus.a;
        2'd1:    data_sel = bus.b;
        2'd2:    data_sel = bus.c;
        default: data_sel = bus.d;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = SEL_BITS'(sel_q);
  assign bus.saida     = data_sel;
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state_q == GRANT);

endmodule

// File: tb/tb_roteador_arbitro.sv
// tb/tb_roteador_arbitro.sv - randomized and directed checks of roteador_arbitro against a queue-free owner/beat model
module tb_roteador_arbitro;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  roteador_arbitro_if #(.DATA_W(4), .SEL_BITS(2)) bus ();

  roteador_arbitro #(.DATA_W(4), .SEL_BITS(2), .MAX_BURST(MAXB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Model: who owns the channel (-1 = nobody), beats accepted so far, rotation start.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr = 0;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic int data_of(input int i);
    case (i)
      0: return int'(bus.a);
      1: return int'(bus.b);
      2: return int'(bus.c);
      default: return int'(bus.d);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit m_live, m_xfer, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_beats = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (bus.req != 4'b0) begin
        m_owner = first_from(bus.req, m_ptr);
        m_beats = 0;
      end
    end else begin
      m_live = bus.req[m_owner];
      m_xfer = m_live && bus.out_ready;
      m_done = !m_live || (m_xfer && (m_beats + 1 == MAXB));
      if (m_done) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = (bus.req != 4'b0) ? first_from(bus.req, m_ptr) : -1;
        m_beats = 0;
      end else if (m_xfer) begin
        m_beats++;
      end
    end
  end

  int e_valid;
  always @(negedge clk) begin
    e_valid = (m_owner >= 0) ? int'(bus.req[m_owner]) : 0;
    chk("busy", int'(bus.busy), (m_owner >= 0) ? 1 : 0);
    chk("gnt", int'(bus.gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("out_valid", int'(bus.out_valid), e_valid);
    chk("saida", int'(bus.saida), (e_valid != 0) ? data_of(m_owner) : 0);
    if (m_owner >= 0) chk("sel", int'(bus.sel), m_owner);
  end

  task automatic restart(input logic [3:0] r);
    rst_n = 1'b0;
    bus.req = 4'b0;
    step();
    bus.req = r;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req = 4'b1111;
    bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_saida", int'(bus.saida), 0);

    // Lone requester c keeps getting re-granted after each full burst.
    bus.req = 4'b0100; bus.c = 4'hA; rst_n = 1'b1;
    step();
    chk("single_gnt", int'(bus.gnt), 4'b0100);
    chk("single_sel", int'(bus.sel), 2);
    chk("single_saida", int'(bus.saida), 4'hA);
    chk("single_valid", int'(bus.out_valid), 1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("single_hold", int'(bus.gnt), 4'b0100);
    end
    bus.req = 4'b0;
    step();
    chk("single_idle", int'(bus.busy), 0);

    // Everyone requesting: four beats each, strict rotation, no gap.
    bus.a = 4'h1; bus.b = 4'h2; bus.c = 4'h3; bus.d = 4'h4;
    restart(4'b1111);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("fair_gnt", int'(bus.gnt), 1 << ((k / 4) % 4));
    end

    // b stalls for three cycles after one beat; three more beats close the burst.
    bus.b = 4'h5; bus.c = 4'h9;
    restart(4'b0110);
    step();
    chk("bp_gnt0", int'(bus.gnt), 4'b0010);
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_gnt", int'(bus.gnt), 4'b0010);
      chk("bp_hold_saida", int'(bus.saida), 4'h5);
    end
    bus.out_ready = 1'b1;
    step();
    step();
    chk("bp_still_b", int'(bus.gnt), 4'b0010);
    step();
    chk("bp_next_gnt", int'(bus.gnt), 4'b0100);
    chk("bp_next_sel", int'(bus.sel), 2);

    // a drops after two beats; d takes over with a fresh four-beat budget.
    restart(4'b1001);
    step();
    chk("drop_a", int'(bus.gnt), 4'b0001);
    step();
    step();
    bus.req = 4'b1000;
    step();
    chk("drop_gnt", int'(bus.gnt), 4'b1000);
    chk("drop_sel", int'(bus.sel), 3);
    bus.req = 4'b1001;
    repeat (3) step();
    chk("drop_d_full", int'(bus.gnt), 4'b1000);
    step();
    chk("drop_back_a", int'(bus.gnt), 4'b0001);

    // Reset pulse between edges while d is mid-burst.
    bus.d = 4'h7;
    restart(4'b1000);
    step();
    chk("ar_d", int'(bus.gnt), 4'b1000);
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("ar_gnt", int'(bus.gnt), 0);
    chk("ar_valid", int'(bus.out_valid), 0);
    chk("ar_busy", int'(bus.busy), 0);
    bus.req = 4'b1001;
    #1 rst_n = 1'b1;
    step();
    chk("ar_first_a", int'(bus.gnt), 4'b0001);
    chk("ar_first_sel", int'(bus.sel), 0);

    for (int k = 0; k < 3000; k++) begin
      step();
      bus.req = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bus.req = bus.req | 4'b1111;
      bus.a = 4'($urandom_range(0, 15));
      bus.b = 4'($urandom_range(0, 15));
      bus.c = 4'($urandom_range(0, 15));
      bus.d = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
